// File: rtl/l2c_tag_arb.sv
// L2C tag-array access controller: arbitrates fill and CPU requests onto the single
// tag-array port and returns each result as a one-cycle response pulse.
module l2c_tag_arb (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        i_fill_check_req,
   input  logic        i_fill_set_req,
   input  logic [31:0] i_fill_adr,
   input  logic [2:0]  i_fill_set_way,
   output logic        o_fill_success,
   output logic        o_fill_fail,
   output logic [2:0]  o_fill_way,
   input  logic        i_cpu_req,
   input  logic [31:0] i_cpu_adr,
   output logic        o_cpu_ack,
   output logic        o_cpu_hit,
   output logic [2:0]  o_cpu_way,
   output logic        o_tag_req,
   output logic [1:0]  o_tag_op,
   output logic [31:0] o_tag_adr,
   output logic [2:0]  o_tag_way,
   input  logic        i_tag_ack,
   input  logic        i_tag_hit,
   input  logic [2:0]  i_tag_way,
   input  logic        i_tag_victim_dirty,
   output logic        o_wb_req,
   output logic [8:0]  o_wb_set,
   output logic [2:0]  o_wb_way,
   input  logic        i_wb_ack_broadcast
);

   localparam int unsigned ADR_W    = 32;
   localparam int unsigned WAY_W    = 3;
   localparam int unsigned SET_W    = 9;
   localparam int unsigned OP_W     = 2;
   localparam int unsigned LINE_LSB = 6;
   localparam int unsigned LINE_W   = ADR_W - LINE_LSB;

   localparam logic [OP_W-1:0] OP_LOOKUP = 2'b00;
   localparam logic [OP_W-1:0] OP_ALLOC  = 2'b01;
   localparam logic [OP_W-1:0] OP_SET    = 2'b10;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

   state_t              state, state_d;
   logic                rr_cpu_last, rr_cpu_last_d;
   logic                pend_vld, pend_vld_d;
   logic [LINE_W-1:0]   pend_adr, pend_adr_d;
   logic                wb_busy, wb_busy_d;

   logic                tag_req_d;
   logic [OP_W-1:0]     tag_op_d;
   logic [ADR_W-1:0]    tag_adr_d;
   logic [WAY_W-1:0]    tag_way_d;
   logic                fill_success_d, fill_fail_d, cpu_ack_d, cpu_hit_d, wb_req_d;
   logic [WAY_W-1:0]    fill_way_d, cpu_way_d, wb_way_d;
   logic [SET_W-1:0]    wb_set_d;

   logic                cpu_elig, chk_elig;

   // CPU lookups to a line whose fill is in flight must wait for the tag set
   assign cpu_elig = i_cpu_req && !(pend_vld && (i_cpu_adr[ADR_W-1:LINE_LSB] == pend_adr));
   assign chk_elig = i_fill_check_req && !wb_busy;

   always_comb begin
      state_d        = state;
      rr_cpu_last_d  = rr_cpu_last;
      pend_vld_d     = pend_vld;
      pend_adr_d     = pend_adr;
      wb_busy_d      = wb_busy && !i_wb_ack_broadcast;
      tag_req_d      = o_tag_req;
      tag_op_d       = o_tag_op;
      tag_adr_d      = o_tag_adr;
      tag_way_d      = o_tag_way;
      fill_success_d = 1'b0;
      fill_fail_d    = 1'b0;
      fill_way_d     = '0;
      cpu_ack_d      = 1'b0;
      cpu_hit_d      = 1'b0;
      cpu_way_d      = '0;
      wb_req_d       = 1'b0;
      wb_set_d       = '0;
      wb_way_d       = '0;

      case (state)
         ST_IDLE: begin
            if (i_fill_set_req || chk_elig || cpu_elig) begin
               state_d   = ST_REQ;
               tag_req_d = 1'b1;
               if (i_fill_set_req) begin
                  tag_op_d  = OP_SET;
                  tag_adr_d = i_fill_adr;
                  tag_way_d = i_fill_set_way;
               end else if (chk_elig && (!cpu_elig || rr_cpu_last)) begin
                  tag_op_d      = OP_ALLOC;
                  tag_adr_d     = i_fill_adr;
                  tag_way_d     = '0;
                  rr_cpu_last_d = 1'b0;
               end else begin
                  tag_op_d      = OP_LOOKUP;
                  tag_adr_d     = i_cpu_adr;
                  tag_way_d     = '0;
                  rr_cpu_last_d = 1'b1;
               end
            end
         end
         ST_REQ: begin
            if (i_tag_ack) begin
               state_d   = ST_RESP;
               tag_req_d = 1'b0;
               tag_op_d  = '0;
               tag_adr_d = '0;
               tag_way_d = '0;
               case (o_tag_op)
                  OP_LOOKUP: begin
                     cpu_ack_d = 1'b1;
                     cpu_hit_d = i_tag_hit;
                     cpu_way_d = i_tag_hit ? i_tag_way : '0;
                  end
                  OP_ALLOC: begin
                     fill_way_d = i_tag_way;
                     if (i_tag_victim_dirty) begin
                        // a new dirty victim overrides a coincident writeback ack
                        fill_fail_d = 1'b1;
                        wb_req_d    = 1'b1;
                        wb_set_d    = o_tag_adr[LINE_LSB +: SET_W];
                        wb_way_d    = i_tag_way;
                        wb_busy_d   = 1'b1;
                     end else begin
                        fill_success_d = 1'b1;
                        pend_vld_d     = 1'b1;
                        pend_adr_d     = o_tag_adr[ADR_W-1:LINE_LSB];
                     end
                  end
                  OP_SET: begin
                     fill_success_d = 1'b1;
                     fill_way_d     = o_tag_way;
                     pend_vld_d     = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state          <= ST_IDLE;
         rr_cpu_last    <= 1'b1;
         pend_vld       <= 1'b0;
         pend_adr       <= '0;
         wb_busy        <= 1'b0;
         o_tag_req      <= 1'b0;
         o_tag_op       <= '0;
         o_tag_adr      <= '0;
         o_tag_way      <= '0;
         o_fill_success <= 1'b0;
         o_fill_fail    <= 1'b0;
         o_fill_way     <= '0;
         o_cpu_ack      <= 1'b0;
         o_cpu_hit      <= 1'b0;
         o_cpu_way      <= '0;
         o_wb_req       <= 1'b0;
         o_wb_set       <= '0;
         o_wb_way       <= '0;
      end else begin
         state          <= state_d;
         rr_cpu_last    <= rr_cpu_last_d;
         pend_vld       <= pend_vld_d;
         pend_adr       <= pend_adr_d;
         wb_busy        <= wb_busy_d;
         o_tag_req      <= tag_req_d;
         o_tag_op       <= tag_op_d;
         o_tag_adr      <= tag_adr_d;
         o_tag_way      <= tag_way_d;
         o_fill_success <= fill_success_d;
         o_fill_fail    <= fill_fail_d;
         o_fill_way     <= fill_way_d;
         o_cpu_ack      <= cpu_ack_d;
         o_cpu_hit      <= cpu_hit_d;
         o_cpu_way      <= cpu_way_d;
         o_wb_req       <= wb_req_d;
         o_wb_set       <= wb_set_d;
         o_wb_way       <= wb_way_d;
      end
   end

endmodule
